bcd_serial_adder: RTL and testbench

Parametrised multi-digit BCD adder that adds two DIGITS-wide packed-BCD operands plus a carry-in, one digit per clock, least-significant digit first. A start/busy/done handshake controls each operation. Invalid-digit detection (any nibble > 9) raises a sticky error flag. An optional seven-segment decode stage drives the board displays directly. It sits between the switch/operand capture logic and the HEX display bank, and generalises the single-digit switch-driven adder/display path to N digits with sequential operation.

---
 rtl/bcd_pkg.sv | 29 ++
 rtl/bcd_serial_adder_if.sv | 31 +++
 rtl/bcd_seg7_decoder.sv | 29 ++
 rtl/bcd_serial_adder.sv | 150 +++++++++++++++
 tb/tb_bcd_serial_adder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder and its display decode.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bcd_pkg;

    // Controller states of the digit-serial adder
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } bcd_state_e;

    localparam int BCD_DIGIT_W = 4;
    localparam int SEG_W       = 7;

    // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle between the operand capture logic and the BCD adder.
// Latency: n/a (wires only); seg exists only when BCD_SEG_EN is defined.
// Backpressure: none; start is a request sampled only when the adder is not busy.
interface bcd_serial_adder_if #(
    parameter int DIGITS = 4
);
    import bcd_pkg::*;

    logic                                 start;
    logic [BCD_DIGIT_W*DIGITS-1:0]        a;
    logic [BCD_DIGIT_W*DIGITS-1:0]        b;
    logic                                 cin;
    logic                                 busy;
    logic                                 done;
    logic [BCD_DIGIT_W*(DIGITS+1)-1:0]    sum;
    logic                                 err;
`ifdef BCD_SEG_EN
    logic [SEG_W*(DIGITS+1)-1:0]          seg;

    modport master (output start, a, b, cin,
                    input  busy, done, sum, err, seg);
    modport slave  (input  start, a, b, cin,
                    output busy, done, sum, err, seg);
`else
    modport master (output start, a, b, cin,
                    input  busy, done, sum, err);
    modport slave  (input  start, a, b, cin,
                    output busy, done, sum, err);
`endif

endinterface

// File: rtl/bcd_seg7_decoder.sv
// One BCD digit to one active-low seven-segment pattern; 10..15 blank the display.
// Latency: combinational.
// Backpressure: none.
module bcd_seg7_decoder
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [SEG_W-1:0]       seg_o
);

    // Glyph lookup; anything outside 0..9 turns every segment off
    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// DIGITS-wide packed-BCD adder, one digit per clock LSD first, sticky invalid-digit flag; BCD_SEG_EN adds 7-seg decode.
// Latency: start sampled at edge k -> busy after k, done pulse and new sum/err after edge k+DIGITS.
// Backpressure: start is ignored while busy (not queued); one result per DIGITS+1 cycles.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    bcd_serial_adder_if.slave bus
);

    localparam int OP_W  = BCD_DIGIT_W * DIGITS;
    localparam int SUM_W = BCD_DIGIT_W * (DIGITS + 1);
    localparam int IDX_W = 3;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_ADD  = 2'(ADD);
    localparam logic [1:0] S_DONE = 2'(DONE);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [OP_W-1:0]  a_q,     a_d;
    logic [OP_W-1:0]  b_q,     b_d;
    logic             carry_q, carry_d;
    logic [OP_W-1:0]  res_q,   res_d;
    logic             inv_q,   inv_d;
    logic [SUM_W-1:0] sum_q,   sum_d;
    logic             err_q,   err_d;

    logic [BCD_DIGIT_W-1:0] a_dig;
    logic [BCD_DIGIT_W-1:0] b_dig;
    logic [4:0]             dig_raw;
    logic [BCD_DIGIT_W-1:0] dig_out;
    logic                   dig_carry;
    logic                   dig_bad;
    logic [OP_W-1:0]        res_upd;

    // Single-digit BCD add of the current slot, with decimal correction
    always_comb begin
        a_dig     = a_q[int'(idx_q)*BCD_DIGIT_W +: BCD_DIGIT_W];
        b_dig     = b_q[int'(idx_q)*BCD_DIGIT_W +: BCD_DIGIT_W];
        dig_raw   = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry_q};
        dig_bad   = (a_dig > 4'd9) || (b_dig > 4'd9);
        dig_out   = dig_raw[BCD_DIGIT_W-1:0];
        dig_carry = 1'b0;
        if (dig_raw > 5'd9) begin
            dig_out   = 4'(dig_raw + 5'd6);
            dig_carry = 1'b1;
        end
        res_upd = res_q;
        res_upd[int'(idx_q)*BCD_DIGIT_W +: BCD_DIGIT_W] = dig_out;
    end

    // Controller: latch operands on start, walk the digits, publish on the last one
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        inv_d   = inv_q;
        sum_d   = sum_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    inv_d   = 1'b0;
                    res_d   = '0;
                    state_d = S_ADD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                res_d   = res_upd;
                carry_d = dig_carry;
                inv_d   = inv_q | dig_bad;
                if (idx_q == IDX_LAST) begin
                    // Result registers load on the same edge that enters DONE
                    state_d = S_DONE;
                    idx_d   = '0;
                    if (inv_q | dig_bad) begin
                        sum_d = '0;
                        err_d = 1'b1;
                    end else begin
                        sum_d = {{(BCD_DIGIT_W-1){1'b0}}, dig_carry, res_upd};
                        err_d = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and working registers; reset aborts any operation in flight
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            inv_q   <= 1'b0;
            sum_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            inv_q   <= inv_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy = (state_q == S_ADD);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.err  = err_q;

`ifdef BCD_SEG_EN
    logic [SEG_W*(DIGITS+1)-1:0] seg_w;

    // One decoder per result digit, fed straight from the registered sum
    for (genvar g = 0; g <= DIGITS; g++) begin : g_seg
        bcd_seg7_decoder u_dec (
            .digit_i (sum_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .seg_o   (seg_w[g*SEG_W +: SEG_W])
        );
    end

    assign bus.seg = seg_w;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder against a decimal-arithmetic reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int OP_W   = 4 * DIGITS;
    localparam int SUM_W  = 4 * (DIGITS + 1);

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;

    bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---- reference model: decimal values, not digit-serial hardware ----
    function automatic bit has_bad(input logic [OP_W-1:0] v);
        for (int i = 0; i < DIGITS; i++)
            if (v[i*4 +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int bcd_val(input logic [OP_W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [SUM_W-1:0] to_bcd(input int n);
        logic [SUM_W-1:0] r = '0;
        int m = n;
        for (int i = 0; i <= DIGITS; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [OP_W-1:0] rand_op(input bit allow_bad);
        logic [OP_W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'($urandom_range(0, 9));
            if (allow_bad && $urandom_range(0, 9) == 0)
                r[i*4 +: 4] = 4'($urandom_range(10, 15));
        end
        return r;
    endfunction

    task automatic check_seg(input string tag, input logic [SUM_W-1:0] xs);
`ifdef BCD_SEG_EN
        for (int i = 0; i <= DIGITS; i++)
            check($sformatf("%s_seg%0d", tag, i), bus.seg[i*7 +: 7], glyph(xs[i*4 +: 4]));
`else
        if (xs === 'x) $display("unexpected unknown in %s", tag);
`endif
    endtask

    // Called at a negedge: request an op, confirm busy rose, then scramble operands
    task automatic launch(input logic [OP_W-1:0] av, input logic [OP_W-1:0] bv, input logic cv);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.cin   = cv;
        @(posedge Clock);
        @(negedge Clock);
        check("busy_after_start", bus.busy, 1);
        bus.start = 1'b0;
        bus.a     = OP_W'($urandom);
        bus.b     = OP_W'($urandom);
        bus.cin   = 1'($urandom);
    endtask

    // Waits (bounded) for done, then checks latency and result against the model
    task automatic finish(input logic [OP_W-1:0] av, input logic [OP_W-1:0] bv,
                          input logic cv, input bit repulse,
                          output logic [SUM_W-1:0] xs);
        int  e = 0;
        bit  bad;
        bad = has_bad(av) || has_bad(bv);
        xs  = bad ? '0 : to_bcd(bcd_val(av) + bcd_val(bv) + int'(cv));
        while (!bus.done && e < DIGITS + 4) begin
            bus.start = repulse && (e == 1 || e == 2);
            @(negedge Clock);
            e++;
        end
        bus.start = 1'b0;
        check("latency", 64'(e), 64'(DIGITS));
        check("sum", bus.sum, xs);
        check("err", bus.err, bad);
        check_seg("res", xs);
    endtask

    // One idle cycle: no spurious done, result held
    task automatic idle_hold(input logic [SUM_W-1:0] xs);
        bus.start = 1'b0;
        @(negedge Clock);
        check("idle_done", bus.done, 0);
        check("idle_busy", bus.busy, 0);
        check("hold_sum", bus.sum, xs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SUM_W-1:0] xs;
        logic [OP_W-1:0]  ra, rb;
        logic             rc;
        int               ndone;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(negedge Clock);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_err", bus.err, 0);
        check_seg("rst", '0);
        Resetn = 1'b1;
        @(negedge Clock);
        check("post_rst_sum", bus.sum, 0);

        // Directed: plain add
        launch(16'h1234, 16'h5678, 1'b0);
        finish(16'h1234, 16'h5678, 1'b0, 1'b0, xs);
        check("dir_1234_5678", bus.sum, 20'h06912);
        idle_hold(xs);

        // Directed: full carry ripple, then back-to-back start during DONE
        launch(16'h9999, 16'h9999, 1'b1);
        finish(16'h9999, 16'h9999, 1'b1, 1'b0, xs);
        check("dir_9999_9999_1", bus.sum, 20'h19999);
        launch(16'h0000, 16'h0000, 1'b0);
        finish(16'h0000, 16'h0000, 1'b0, 1'b0, xs);
        check("b2b_zero", bus.sum, 20'h00000);
        idle_hold(xs);

        // Directed: invalid digit, then recovery
        launch(16'h12A4, 16'h0001, 1'b0);
        finish(16'h12A4, 16'h0001, 1'b0, 1'b0, xs);
        check("bad_err", bus.err, 1);
        idle_hold(xs);
        launch(16'h0001, 16'h0001, 1'b0);
        finish(16'h0001, 16'h0001, 1'b0, 1'b0, xs);
        check("recover_sum", bus.sum, 20'h00002);
        check("recover_err", bus.err, 0);
        idle_hold(xs);

        // start re-pulsed mid-ADD must be ignored
        launch(16'h4821, 16'h3760, 1'b1);
        finish(16'h4821, 16'h3760, 1'b1, 1'b1, xs);
        repeat (3) idle_hold(xs);

        // Small result for the display decode
        launch(16'h0005, 16'h0003, 1'b0);
        finish(16'h0005, 16'h0003, 1'b0, 1'b0, xs);
        check("dir_8", bus.sum, 20'h00008);
        idle_hold(xs);

        // Randomized ops, sometimes back-to-back
        for (int n = 0; n < 30; n++) begin
            ra = rand_op(1'b1);
            rb = rand_op(1'b1);
            rc = 1'($urandom);
            launch(ra, rb, rc);
            finish(ra, rb, rc, 1'($urandom_range(0, 3) == 0), xs);
            if ($urandom_range(0, 1) == 0) idle_hold(xs);
        end
        idle_hold(xs);

        // Abort mid-operation with a non-zero result on display
        launch(16'h1111, 16'h2222, 1'b0);
        finish(16'h1111, 16'h2222, 1'b0, 1'b0, xs);
        idle_hold(xs);
        launch(16'h4444, 16'h1111, 1'b0);
        repeat (2) @(negedge Clock);
        Resetn = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_sum", bus.sum, 0);
        check("abort_err", bus.err, 0);
        check_seg("abort", '0);
        @(negedge Clock);
        Resetn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (bus.done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 0);
        check("abort_idle_busy", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
